bram_port_arbiter: RTL and testbench
====================================

// Module: bram_port_arbiter
// PURPOSE
//  Shares one BlockRAM port (packed {addr,data,wr} request, valid/bp handshake) among NumReq
//  requesters using round-robin arbitration with exactly one transaction in flight.
//  Sits between LLPM-generated client logic and one port of a BlockRAM_* instance.
//  Each accepted request yields exactly one response to the same requester; writes also respond.
// PARAMETERS
//  Name      ""  instance name string, passed through for debug only
//  NumReq    4   number of requesters, >=2
//  Width     8   RAM data width
//  AddrWidth 8   RAM address width
//  CntWidth  16  grant-counter width (used only with BRAM_ARB_STATS_EN)
//  localparams: ReqWidth = Width+AddrWidth+1; GntWidth = $clog2(NumReq)
// PORTS
//  clk            in  1                 clock, all state on posedge
//  resetn         in  1                 asynchronous active-low reset
//  req            in  NumReq*ReqWidth   requester i at slice i; bit0=wr, [Width:1]=data, top=addr
//  req_valid      in  NumReq            request valid per requester
//  req_bp         out NumReq            backpressure per requester (1 = not accepted)
//  resp           out Width             response data, shared by all requesters
//  resp_valid     out NumReq            one-hot; response valid for requester i
//  resp_bp        in  NumReq            backpressure from requester i's response sink
//  mem_req        out ReqWidth          request to RAM port
//  mem_req_valid  out 1
//  mem_req_bp     in  1
//  mem_resp       in  Width             RAM read data
//  mem_resp_valid in  1
//  mem_resp_bp    out 1
// BEHAVIOUR
//  Reset (async assert, sync-safe deassert): state=IDLE, last_gnt=NumReq-1, req_bp=all 1,
//   resp_valid=0, resp=0, mem_req_valid=0, mem_req=0, mem_resp_bp=1, counters=0.
//  FSM IDLE -> ISSUE -> RESP -> IDLE.
//  IDLE: winner = first i with req_valid[i], searching from last_gnt+1 upward, wrapping mod NumReq.
//   If a winner exists: req_bp[winner]=0 combinationally (accept this cycle), latch req slice
//   into req_q, gnt<=winner, go to ISSUE. All other req_bp bits stay 1. No winner: stay.
//  ISSUE: mem_req=req_q, mem_req_valid=1, mem_resp_bp=0. Transfer when mem_req_valid&~mem_req_bp;
//   capture mem_resp into resp_q when mem_resp_valid&~mem_resp_bp, then go to RESP.
//   The RAM returns its response in the same cycle as the request; a response without
//   transfer is ignored. Stay in ISSUE while mem_req_bp=1.
//  RESP: resp=resp_q, resp_valid[gnt]=1 only. On ~resp_bp[gnt]: last_gnt<=gnt, go to IDLE.
//  Latency: accept cycle N -> RAM issue at N+1 (no stall) -> resp_valid at N+2.
//   Peak throughput is one transaction per 3 cycles.
//  req_bp for every requester is 1 outside IDLE. resp holds resp_q (0 after reset) otherwise.
//  Fairness: a continuously-valid requester waits at most NumReq-1 grants.
//  A requester dropping req_valid in IDLE before acceptance is legal; it is not latched.
//  Reset mid-operation: the transaction is discarded without a response. A write already
//   transferred in ISSUE stays in RAM; a write not yet transferred is lost.
// CONFIGURATION
//  BRAM_ARB_STATS_EN defined: adds output stat_grants [NumReq*CntWidth-1:0]. Counter i
//   increments on each IDLE acceptance of requester i and saturates at all-ones.
//   Counters clear on reset.
//  BRAM_ARB_STATS_EN undefined: the port and counters are absent. All other behaviour is identical.
// STRUCTURE
//  Package llpm_mem_pkg: state enum {IDLE,ISSUE,RESP}; req field-offset functions
//   (wr bit, data slice, addr slice) reused by BlockRAM users.
//  Sub-module rr_pick: combinational round-robin picker (valid vector, last_gnt -> winner, any).
//  The FSM, latches and counters live in bram_port_arbiter.
// TESTING
//  1. Requester 0 writes addr 5 data 0xA5, then reads addr 5 -> two responses to
//     requester 0, second resp=0xA5; accept cycles 3 apart.
//  2. All 4 req_valid held high from reset -> grant order 0,1,2,3,0,1; one resp_valid
//     per grant, to the matching requester.
//  3. mem_req_bp held high 5 cycles in ISSUE -> no response and all req_bp=1;
//     response 1 cycle after bp drops.
//  4. resp_bp[2]=1 for 4 cycles during RESP -> resp and resp_valid[2] stable,
//     no new acceptance until released.
//  5. resetn asserted in RESP -> outputs return to reset values immediately; next grant goes
//     to requester 0; the previously written value is readable.
//  6. BRAM_ARB_STATS_EN, CntWidth=2, requester 1 granted 5 times -> counter 1 saturates at 3.

Source files
------------

// File: rtl/llpm_mem_pkg.sv
// ---------------------------------------------------------------------------
// llpm_mem_pkg
//   Shared types and request-field helpers for BlockRAM port users.
//   A packed RAM request is {addr, data, wr}:
//     bit 0                 : wr (1 = write, 0 = read)
//     [Width:1]             : write data
//     [Width+AddrWidth:W+1] : address
// ---------------------------------------------------------------------------
package llpm_mem_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } arb_state_t;

   // Bit position of the write flag within a packed request.
   function automatic int unsigned req_wr_bit();
      return 0;
   endfunction

   // LSB of the data field within a packed request.
   function automatic int unsigned req_data_lsb();
      return 1;
   endfunction

   // LSB of the address field for a given data width.
   function automatic int unsigned req_addr_lsb(input int unsigned width);
      return width + 1;
   endfunction

endpackage

// File: rtl/bram_port_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin picker.
//   Ports:
//     valid    in  NumReq    request vector
//     last_gnt in  GntWidth  most recently completed grant
//     winner   out GntWidth  first valid index after last_gnt, wrapping
//     any      out 1         some requester is valid
// ---------------------------------------------------------------------------
module rr_pick #(
   parameter int unsigned NumReq   = 4,
   parameter int unsigned GntWidth = $clog2(NumReq)
) (
   input  logic [NumReq-1:0]   valid,
   input  logic [GntWidth-1:0] last_gnt,
   output logic [GntWidth-1:0] winner,
   output logic                any
);

   always_comb begin
      int unsigned         idx;
      logic [GntWidth-1:0] idx_g;
      winner = '0;
      any    = 1'b0;
      idx    = 0;
      idx_g  = '0;
      for (int unsigned k = 1; k <= NumReq; k++) begin
         idx   = (32'(last_gnt) + k) % NumReq;
         idx_g = idx[GntWidth-1:0];
         if (!any && valid[idx_g]) begin
            any    = 1'b1;
            winner = idx_g;
         end
      end
   end

endmodule

// File: rtl/bram_port_arbiter.sv
// ---------------------------------------------------------------------------
// bram_port_arbiter
//   Round-robin sharing of one BlockRAM port among NumReq requesters with a
//   single transaction in flight (IDLE -> ISSUE -> RESP -> IDLE).
//   Ports:
//     clk, resetn             clock, async active-low reset
//     req/req_valid/req_bp    per-requester packed {addr,data,wr} requests
//     resp/resp_valid/resp_bp shared response data, one-hot valid per requester
//     mem_req*/mem_resp*      RAM port (response returned with the request)
//   Optional: define BRAM_ARB_STATS_EN to add stat_grants, NumReq saturating
//   CntWidth-bit acceptance counters (requester i at slice i).
// ---------------------------------------------------------------------------
module bram_port_arbiter
   import llpm_mem_pkg::*;
#(
   parameter string       Name      = "",
   parameter int unsigned NumReq    = 4,
   parameter int unsigned Width     = 8,
   parameter int unsigned AddrWidth = 8,
   parameter int unsigned CntWidth  = 16,
   localparam int unsigned ReqWidth = Width + AddrWidth + 1,
   localparam int unsigned GntWidth = $clog2(NumReq)
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic [NumReq*ReqWidth-1:0] req,
   input  logic [NumReq-1:0]          req_valid,
   output logic [NumReq-1:0]          req_bp,
   output logic [Width-1:0]           resp,
   output logic [NumReq-1:0]          resp_valid,
   input  logic [NumReq-1:0]          resp_bp,
   output logic [ReqWidth-1:0]        mem_req,
   output logic                       mem_req_valid,
   input  logic                       mem_req_bp,
   input  logic [Width-1:0]           mem_resp,
   input  logic                       mem_resp_valid,
   output logic                       mem_resp_bp
`ifdef BRAM_ARB_STATS_EN
   ,
   output logic [NumReq*CntWidth-1:0] stat_grants
`endif
);

   arb_state_t          state, state_nxt;
   logic [GntWidth-1:0] last_gnt, gnt, pick;
   logic                pick_any, accept, xfer, resp_done;
   logic [ReqWidth-1:0] req_q;
   logic [Width-1:0]    resp_q;
   logic [ReqWidth-1:0] req_slice [NumReq];

   for (genvar i = 0; i < NumReq; i++) begin : g_slice
      assign req_slice[i] = req[i*ReqWidth +: ReqWidth];
   end

   rr_pick #(
      .NumReq   (NumReq),
      .GntWidth (GntWidth)
   ) u_pick (
      .valid    (req_valid),
      .last_gnt (last_gnt),
      .winner   (pick),
      .any      (pick_any)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   // Acceptance is gated by resetn so req_bp reads all-ones while reset is held.
   always_comb begin
      state_nxt     = state;
      req_bp        = '1;
      resp_valid    = '0;
      mem_req       = '0;
      mem_req_valid = 1'b0;
      mem_resp_bp   = 1'b1;
      accept        = 1'b0;
      xfer          = 1'b0;
      resp_done     = 1'b0;
      case (state)
         IDLE: begin
            if (pick_any && resetn) begin
               accept       = 1'b1;
               req_bp[pick] = 1'b0;
               state_nxt    = ISSUE;
            end
         end
         ISSUE: begin
            mem_req       = req_q;
            mem_req_valid = 1'b1;
            mem_resp_bp   = 1'b0;
            if (!mem_req_bp) begin
               xfer      = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP: begin
            resp_valid[gnt] = 1'b1;
            if (!resp_bp[gnt]) begin
               resp_done = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign resp = resp_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         last_gnt <= GntWidth'(NumReq - 1);
         gnt      <= '0;
         req_q    <= '0;
         resp_q   <= '0;
      end else begin
         if (accept) begin
            gnt   <= pick;
            req_q <= req_slice[pick];
         end
         // The RAM answers in the transfer cycle; a response outside it is dropped.
         if (xfer && mem_resp_valid) resp_q <= mem_resp;
         if (resp_done) last_gnt <= gnt;
      end
   end

   always_ff @(posedge clk) begin
      if (resetn && state != IDLE)
         assert (32'(gnt) < NumReq && CntWidth > 0)
            else $error("bram_port_arbiter %s: grant %0d out of range", Name, gnt);
   end

`ifdef BRAM_ARB_STATS_EN
   logic [CntWidth-1:0] grant_cnt [NumReq];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int unsigned i = 0; i < NumReq; i++) grant_cnt[i] <= '0;
      end else if (accept && grant_cnt[pick] != '1) begin
         grant_cnt[pick] <= grant_cnt[pick] + 1'b1;
      end
   end

   for (genvar i = 0; i < NumReq; i++) begin : g_stat
      assign stat_grants[i*CntWidth +: CntWidth] = grant_cnt[i];
   end
`endif

endmodule

// File: tb/tb_bram_port_arbiter.sv
module tb_bram_port_arbiter;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int AW = 8;
   localparam int RW = W + AW + 1;
`ifdef BRAM_ARB_STATS_EN
   localparam int CW = 2;
`else
   localparam int CW = 16;
`endif

   logic            clk = 1'b0;
   logic            resetn;
   logic [N*RW-1:0] req;
   logic [N-1:0]    req_valid, req_bp, resp_valid, resp_bp;
   logic [W-1:0]    resp, mem_resp;
   logic [RW-1:0]   mem_req;
   logic            mem_req_valid, mem_req_bp, mem_resp_valid, mem_resp_bp;
`ifdef BRAM_ARB_STATS_EN
   logic [N*CW-1:0] stat_grants;
`endif

   int checks = 0;
   int errors = 0;

   // RAM environment: read-first, response in the transfer cycle.
   logic [W-1:0] ram [256];
   logic [W-1:0] model_mem [256];

   assign mem_resp_valid = mem_req_valid & ~mem_req_bp;
   assign mem_resp       = ram[mem_req[RW-1:W+1]];

   always @(posedge clk)
      if (mem_req_valid && !mem_req_bp && mem_req[0])
         ram[mem_req[RW-1:W+1]] <= mem_req[W:1];

   always #5 clk = ~clk;

   bram_port_arbiter #(
      .Name      ("tb_arb"),
      .NumReq    (N),
      .Width     (W),
      .AddrWidth (AW),
      .CntWidth  (CW)
   ) dut (
      .clk            (clk),
      .resetn         (resetn),
      .req            (req),
      .req_valid      (req_valid),
      .req_bp         (req_bp),
      .resp           (resp),
      .resp_valid     (resp_valid),
      .resp_bp        (resp_bp),
      .mem_req        (mem_req),
      .mem_req_valid  (mem_req_valid),
      .mem_req_bp     (mem_req_bp),
      .mem_resp       (mem_resp),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_bp    (mem_resp_bp)
`ifdef BRAM_ARB_STATS_EN
      ,
      .stat_grants    (stat_grants)
`endif
   );

   function automatic logic [RW-1:0] mk_req(input logic [AW-1:0] a, input logic [W-1:0] d,
                                           input logic w);
      return {a, d, w};
   endfunction

   task automatic set_req(input int i, input logic [RW-1:0] r);
      req[i*RW +: RW] = r;
   endtask

   task automatic do_reset();
      @(negedge clk);
      resetn = 1'b0; req_valid = '0; resp_bp = '0; mem_req_bp = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic test_reset();
      resetn = 1'b0; req_valid = '1; resp_bp = '0; mem_req_bp = 1'b0;
      for (int i = 0; i < N; i++) set_req(i, mk_req(8'(i), 8'h11, 1'b0));
      repeat (2) @(negedge clk);
      #1;
      checks++; if (req_bp !== 4'hF) begin errors++; $display("FAIL reset_req_bp got %h exp %h", req_bp, 4'hF); end
      checks++; if (resp_valid !== 4'h0) begin errors++; $display("FAIL reset_resp_valid got %h exp %h", resp_valid, 4'h0); end
      checks++; if (resp !== 8'h00) begin errors++; $display("FAIL reset_resp got %h exp %h", resp, 8'h00); end
      checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_req_valid got %b exp 0", mem_req_valid); end
      checks++; if (mem_req !== '0) begin errors++; $display("FAIL reset_mem_req got %h exp 0", mem_req); end
      checks++; if (mem_resp_bp !== 1'b1) begin errors++; $display("FAIL reset_mem_resp_bp got %b exp 1", mem_resp_bp); end
      @(negedge clk);
      req_valid = '0; resetn = 1'b1;
   endtask

   task automatic test_write_read();
      logic [W-1:0] old;
      do_reset();
      old = model_mem[5];
      @(negedge clk); set_req(0, mk_req(8'd5, 8'hA5, 1'b1)); req_valid = 4'b0001; #1;
      checks++; if (req_bp !== 4'hE) begin errors++; $display("FAIL wr_accept req_bp got %h exp %h", req_bp, 4'hE); end
      @(negedge clk); set_req(0, mk_req(8'd5, 8'h00, 1'b0)); #1;
      checks++; if (mem_req_valid !== 1'b1 || mem_req !== mk_req(8'd5, 8'hA5, 1'b1)) begin
         errors++; $display("FAIL wr_issue mem_req got %h/%b exp %h/1", mem_req, mem_req_valid, mk_req(8'd5, 8'hA5, 1'b1)); end
      checks++; if (req_bp !== 4'hF) begin errors++; $display("FAIL wr_issue req_bp got %h exp %h", req_bp, 4'hF); end
      @(negedge clk); #1;
      checks++; if (resp_valid !== 4'b0001 || resp !== old) begin
         errors++; $display("FAIL wr_resp got %h/%h exp %h/%h", resp_valid, resp, 4'b0001, old); end
      model_mem[5] = 8'hA5;
      @(negedge clk); #1;
      checks++; if (req_bp !== 4'hE) begin errors++; $display("FAIL rd_accept_3_later req_bp got %h exp %h", req_bp, 4'hE); end
      @(negedge clk); req_valid = '0; #1;
      checks++; if (mem_req !== mk_req(8'd5, 8'h00, 1'b0)) begin
         errors++; $display("FAIL rd_issue mem_req got %h exp %h", mem_req, mk_req(8'd5, 8'h00, 1'b0)); end
      @(negedge clk); #1;
      checks++; if (resp_valid !== 4'b0001 || resp !== 8'hA5) begin
         errors++; $display("FAIL rd_resp got %h/%h exp %h/%h", resp_valid, resp, 4'b0001, 8'hA5); end
   endtask

   task automatic test_round_robin();
      int gq[$];
      int ng, nr, prev;
      logic [N-1:0] oh;
      do_reset();
      for (int i = 0; i < N; i++) set_req(i, mk_req(8'(16 + i), 8'h00, 1'b0));
      ng = 0; nr = 0; prev = N - 1;
      @(negedge clk); req_valid = '1;
      for (int c = 0; c < 40 && (ng < 6 || nr < 6); c++) begin
         #1;
         if (req_bp !== 4'hF) begin
            prev = (prev + 1) % N;
            oh = ~(4'b0001 << prev);
            checks++; if (req_bp !== oh) begin errors++; $display("FAIL rr_grant%0d req_bp got %h exp %h", ng, req_bp, oh); end
            gq.push_back(prev);
            ng++;
         end
         if (resp_valid !== 4'h0) begin
            if (nr < gq.size()) begin
               oh = 4'b0001 << gq[nr];
               checks++; if (resp_valid !== oh || resp !== model_mem[16 + gq[nr]]) begin
                  errors++; $display("FAIL rr_resp%0d got %h/%h exp %h/%h", nr, resp_valid, resp, oh, model_mem[16 + gq[nr]]); end
            end else begin
               checks++; errors++; $display("FAIL rr_resp_unexpected got %h exp 0", resp_valid);
            end
            nr++;
         end
         @(negedge clk);
      end
      req_valid = '0;
      checks++; if (ng < 6 || nr < 6) begin errors++; $display("FAIL rr_timeout grants %0d resps %0d exp 6/6", ng, nr); end
   endtask

   task automatic test_mem_stall();
      do_reset();
      mem_req_bp = 1'b1;
      set_req(0, mk_req(8'd1, 8'h00, 1'b0)); set_req(1, mk_req(8'd2, 8'h00, 1'b0));
      set_req(3, mk_req(8'd3, 8'h00, 1'b0));
      @(negedge clk); set_req(2, mk_req(8'd7, 8'h00, 1'b0)); req_valid = 4'b0100; #1;
      checks++; if (req_bp !== 4'b1011) begin errors++; $display("FAIL stall_accept req_bp got %h exp %h", req_bp, 4'b1011); end
      for (int k = 0; k < 5; k++) begin
         @(negedge clk); req_valid = 4'b1011; #1;
         checks++; if (resp_valid !== 4'h0 || req_bp !== 4'hF || mem_req_valid !== 1'b1) begin
            errors++; $display("FAIL stall_hold%0d got rv %h bp %h mv %b exp 0/f/1", k, resp_valid, req_bp, mem_req_valid); end
      end
      @(negedge clk); mem_req_bp = 1'b0; #1;
      checks++; if (resp_valid !== 4'h0) begin errors++; $display("FAIL stall_release got %h exp 0", resp_valid); end
      @(negedge clk); req_valid = '0; #1;
      checks++; if (resp_valid !== 4'b0100 || resp !== model_mem[7]) begin
         errors++; $display("FAIL stall_resp got %h/%h exp %h/%h", resp_valid, resp, 4'b0100, model_mem[7]); end
   endtask

   task automatic test_resp_stall();
      do_reset();
      resp_bp = 4'b0100;
      @(negedge clk); set_req(2, mk_req(8'd9, 8'h00, 1'b0)); req_valid = 4'b0100; #1;
      checks++; if (req_bp !== 4'b1011) begin errors++; $display("FAIL rbp_accept req_bp got %h exp %h", req_bp, 4'b1011); end
      @(negedge clk);
      set_req(0, mk_req(8'd1, 8'h00, 1'b0)); set_req(1, mk_req(8'd2, 8'h00, 1'b0));
      req_valid = 4'b0011;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); #1;
         checks++; if (resp_valid !== 4'b0100 || resp !== model_mem[9] || req_bp !== 4'hF) begin
            errors++; $display("FAIL rbp_hold%0d got %h/%h/%h exp %h/%h/f", k, resp_valid, resp, req_bp, 4'b0100, model_mem[9]); end
      end
      @(negedge clk); resp_bp = '0; #1;
      checks++; if (resp_valid !== 4'b0100) begin errors++; $display("FAIL rbp_release got %h exp %h", resp_valid, 4'b0100); end
      @(negedge clk); #1;
      checks++; if (req_bp !== 4'b1110) begin errors++; $display("FAIL rbp_wrap_grant req_bp got %h exp %h", req_bp, 4'b1110); end
      @(negedge clk); req_valid = '0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      @(negedge clk); set_req(0, mk_req(8'd2, 8'h00, 1'b0)); req_valid = 4'b0001; #1;
      checks++; if (req_bp !== 4'hE) begin errors++; $display("FAIL rmid_pre_accept req_bp got %h exp %h", req_bp, 4'hE); end
      @(negedge clk); req_valid = '0;
      repeat (2) @(negedge clk);
      @(negedge clk); set_req(1, mk_req(8'h33, 8'h5C, 1'b1)); req_valid = 4'b0010; #1;
      checks++; if (req_bp !== 4'b1101) begin errors++; $display("FAIL rmid_wr_accept req_bp got %h exp %h", req_bp, 4'b1101); end
      @(negedge clk); req_valid = '0;
      @(negedge clk); #1;
      checks++; if (resp_valid !== 4'b0010) begin errors++; $display("FAIL rmid_in_resp got %h exp %h", resp_valid, 4'b0010); end
      resetn = 1'b0;
      set_req(0, mk_req(8'h33, 8'h00, 1'b0)); set_req(1, mk_req(8'h44, 8'h00, 1'b0));
      req_valid = 4'b0011; #1;
      checks++; if (resp_valid !== 4'h0 || resp !== 8'h00 || req_bp !== 4'hF || mem_req_valid !== 1'b0 || mem_resp_bp !== 1'b1) begin
         errors++; $display("FAIL rmid_reset_outputs got %h/%h/%h/%b/%b exp 0/0/f/0/1", resp_valid, resp, req_bp, mem_req_valid, mem_resp_bp); end
      model_mem[8'h33] = 8'h5C;
      @(negedge clk); resetn = 1'b1; #1;
      checks++; if (req_bp !== 4'b1110) begin errors++; $display("FAIL rmid_first_grant req_bp got %h exp %h", req_bp, 4'b1110); end
      @(negedge clk); req_valid = '0;
      @(negedge clk); #1;
      checks++; if (resp_valid !== 4'b0001 || resp !== 8'h5C) begin
         errors++; $display("FAIL rmid_readback got %h/%h exp %h/%h", resp_valid, resp, 4'b0001, 8'h5C); end
   endtask

   task automatic test_random();
      bit            vld [N];
      logic [RW-1:0] rq [N];
      bit            busy_issue, busy_resp, found;
      int            who, last, w;
      logic [RW-1:0] cur;
      logic [W-1:0]  cur_exp;
      logic [N-1:0]  exp_bp, exp_rv;
      do_reset();
      for (int i = 0; i < N; i++) vld[i] = 1'b0;
      busy_issue = 0; busy_resp = 0; who = 0; last = N - 1; cur = '0; cur_exp = '0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            if (!vld[i]) begin
               if ($urandom_range(0, 2) == 0) begin
                  vld[i] = 1'b1;
                  rq[i]  = mk_req(8'($urandom_range(0, 15)), 8'($urandom), 1'($urandom));
               end
            end else if ($urandom_range(0, 15) == 0) begin
               vld[i] = 1'b0;
            end
            req_valid[i] = vld[i];
            if (vld[i]) set_req(i, rq[i]);
         end
         resp_bp    = 4'($urandom) & 4'($urandom);
         mem_req_bp = ($urandom_range(0, 3) == 0);
         #1;
         found = 0; w = 0;
         if (!busy_issue && !busy_resp)
            for (int k = 1; k <= N; k++)
               if (!found && vld[(last + k) % N]) begin found = 1; w = (last + k) % N; end
         exp_bp = '1;
         if (found) exp_bp[w] = 1'b0;
         checks++; if (req_bp !== exp_bp) begin errors++; $display("FAIL rnd_req_bp c%0d got %h exp %h", c, req_bp, exp_bp); end
         checks++; if (mem_req_valid !== busy_issue || (busy_issue && mem_req !== cur)) begin
            errors++; $display("FAIL rnd_mem_req c%0d got %b/%h exp %b/%h", c, mem_req_valid, mem_req, busy_issue, cur); end
         checks++; if (mem_resp_bp !== !busy_issue) begin errors++; $display("FAIL rnd_mem_resp_bp c%0d got %b exp %b", c, mem_resp_bp, !busy_issue); end
         exp_rv = busy_resp ? (4'b0001 << who) : 4'b0000;
         checks++; if (resp_valid !== exp_rv || (busy_resp && resp !== cur_exp)) begin
            errors++; $display("FAIL rnd_resp c%0d got %h/%h exp %h/%h", c, resp_valid, resp, exp_rv, cur_exp); end
         if (found) begin
            busy_issue = 1; who = w; cur = rq[w]; vld[w] = 1'b0;
         end else if (busy_issue && !mem_req_bp) begin
            busy_issue = 0; busy_resp = 1;
            cur_exp = model_mem[cur[RW-1:W+1]];
            if (cur[0]) model_mem[cur[RW-1:W+1]] = cur[W:1];
         end else if (busy_resp && !resp_bp[who]) begin
            busy_resp = 0; last = who;
         end
      end
      @(negedge clk);
      req_valid = '0; resp_bp = '0; mem_req_bp = 1'b0;
      repeat (3) @(negedge clk);
   endtask

`ifdef BRAM_ARB_STATS_EN
   task automatic test_stats();
      int n;
      logic [CW-1:0] exp_c;
      do_reset();
      n = 0;
      set_req(1, mk_req(8'd3, 8'h00, 1'b0));
      @(negedge clk); req_valid = 4'b0010;
      for (int c = 0; c < 40 && n < 5; c++) begin
         #1;
         exp_c = (n < 3) ? CW'(n) : CW'(3);
         checks++; if (stat_grants[1*CW +: CW] !== exp_c) begin
            errors++; $display("FAIL stats_cnt1 n%0d got %0d exp %0d", n, stat_grants[1*CW +: CW], exp_c); end
         if (req_bp[1] === 1'b0) n++;
         @(negedge clk);
      end
      req_valid = '0;
      checks++; if (n != 5) begin errors++; $display("FAIL stats_timeout grants %0d exp 5", n); end
      repeat (3) @(negedge clk);
      #1;
      checks++; if (stat_grants !== {2'd0, 2'd0, 2'd3, 2'd0}) begin
         errors++; $display("FAIL stats_final got %h exp %h", stat_grants, {2'd0, 2'd0, 2'd3, 2'd0}); end
   endtask
`endif

   initial begin
      logic [W-1:0] v;
      for (int i = 0; i < 256; i++) begin
         v = 8'($urandom_range(1, 255));
         ram[i] <= v;
         model_mem[i] = v;
      end
      req = '0; req_valid = '0; resp_bp = '0; mem_req_bp = 1'b0; resetn = 1'b0;
      test_reset();
      test_write_read();
      test_round_robin();
      test_mem_stall();
      test_resp_stall();
      test_reset_mid();
      test_random();
`ifdef BRAM_ARB_STATS_EN
      test_stats();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish, checks %0d errors %0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
